// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and next-PC sequencer for the single-cycle core.
// Fetches over a req/ready port, issues the word to the decoder, then resolves jr/jump/branch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic        adr_r31,
    input  logic [31:0] r31_data,
    output logic [31:0] instr_count,
    output logic        err_misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_q;
    logic        started_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        err_q;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic [31:0] pc_d;
    logic        misalign_d;

    // Next-PC selection: jr beats jump beats a taken branch beats fall-through.
    always_comb begin
        pc_plus4_w  = pc_q + 32'd4;
        branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jr_target   = {r31_data[31:2], 2'b00};
        jump_target = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        pc_d        = pc_plus4_w;
        misalign_d  = 1'b0;
        if (adr_r31) begin
            pc_d       = jr_target;
            misalign_d = |r31_data[1:0];
        end else if (jump) begin
            pc_d = jump_target;
        end else if (branch && zero) begin
            pc_d = pc_plus4_w + branch_off;
        end
    end

    // IDLE waits one extra cycle after reset release so the first request
    // appears on the second edge with reset high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            count_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    started_q <= 1'b1;
                    if (started_q) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= ISSUE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc_q    <= pc_d;
                        count_q <= count_q + 32'd1;
                        if (misalign_d) begin
                            err_q <= 1'b1;
                        end
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[31:26];
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_w;
    assign instr_count  = count_q;
    assign err_misalign = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A second instance with RESET_PC at the top of memory exercises address wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        jump;
    logic        branch;
    logic        zero;
    logic        adr_r31;
    logic [31:0] r31_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;
    logic        err_misalign;

    logic        rst1;
    logic        imem_ready1;
    logic [31:0] imem_rdata1;
    logic        exec_done1;
    logic        branch1;
    logic        zero1;
    logic        imem_req1;
    logic [31:0] imem_addr1;
    logic [31:0] instr1;
    logic [5:0]  opcode1;
    logic        instr_valid1;
    logic [31:0] pc1;
    logic [31:0] pc_plus4_1;
    logic [31:0] instr_count1;
    logic        err_misalign1;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .exec_done(exec_done), .jump(jump), .branch(branch), .zero(zero),
        .adr_r31(adr_r31), .r31_data(r31_data),
        .instr_count(instr_count), .err_misalign(err_misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst(rst1),
        .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ready(imem_ready1), .imem_rdata(imem_rdata1),
        .instr(instr1), .opcode(opcode1), .instr_valid(instr_valid1),
        .pc(pc1), .pc_plus4(pc_plus4_1),
        .exec_done(exec_done1), .jump(1'b0), .branch(branch1), .zero(zero1),
        .adr_r31(1'b0), .r31_data(32'd0),
        .instr_count(instr_count1), .err_misalign(err_misalign1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: deliver one word with zero wait, then retire it with the given controls.
    task automatic fetch_issue(input logic [31:0] word, input logic j, input logic b,
                               input logic z, input logic r, input logic [31:0] r31);
        imem_ready = 1'b1;
        imem_rdata = word;
        exec_done  = 1'b0;
        tick();
        imem_ready = 1'b0;
        jump       = j;
        branch     = b;
        zero       = z;
        adr_r31    = r;
        r31_data   = r31;
        exec_done  = 1'b1;
        tick();
        exec_done  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        adr_r31    = 1'b0;
        r31_data   = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        imem_ready = 1'b1;
        exec_done = 1'b1;
        tick();
        tick();
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_quiet: req=%b valid=%b want 0 0", imem_req, instr_valid);
        end
        total++;
        if (pc !== 32'd0 || instr !== 32'd0 || instr_count !== 32'd0 || err_misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_regs: pc=%h instr=%h cnt=%0d err=%b want 0 0 0 0",
                     pc, instr, instr_count, err_misalign);
        end
        imem_ready = 1'b0;
        exec_done = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL first_edge_req: got %b want 0", imem_req);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++;
            $display("[TB] FAIL second_edge_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words [2];
        logic [31:0] exp_pc;
        words[0] = 32'h0022_1820;
        words[1] = 32'h0085_3020;
        exp_pc = 32'd0;
        exec_done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            imem_ready = 1'b1;
            imem_rdata = words[k];
            tick();
            total++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== words[k] || opcode !== 6'd0) begin
                bad++;
                $display("[TB] FAIL seq_issue%0d: valid=%b req=%b instr=%h op=%h want 1 0 %h 00",
                         k, instr_valid, imem_req, instr, opcode, words[k]);
            end
            total++;
            if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
                bad++;
                $display("[TB] FAIL seq_pc%0d: pc=%h pc4=%h want %h %h", k, pc, pc_plus4, exp_pc, exp_pc + 32'd4);
            end
            imem_ready = 1'b0;
            tick();
            exp_pc = exp_pc + 32'd4;
            total++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
                bad++;
                $display("[TB] FAIL seq_fetch%0d: req=%b valid=%b addr=%h want 1 0 %h",
                         k, imem_req, instr_valid, imem_addr, exp_pc);
            end
        end
    endtask

    task automatic test_wait_states();
        // exec_done stays high throughout to show it is ignored in FETCH.
        exec_done = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd8 || instr_valid !== 1'b0 || instr !== 32'h0085_3020) begin
                bad++;
                $display("[TB] FAIL wait%0d: req=%b addr=%h valid=%b instr=%h want 1 8 0 00853020",
                         i, imem_req, imem_addr, instr_valid, instr);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h00E7_4020;
        tick();
        imem_ready = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h00E7_4020 || pc !== 32'd8) begin
            bad++;
            $display("[TB] FAIL wait_capture: valid=%b instr=%h pc=%h want 1 00e74020 8", instr_valid, instr, pc);
        end
        tick();
        exec_done = 1'b0;
        total++;
        if (instr_count !== 32'd3 || imem_addr !== 32'd12 || imem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL count3: cnt=%0d addr=%h req=%b want 3 c 1", instr_count, imem_addr, imem_req);
        end
    endtask

    task automatic test_branch();
        fetch_issue(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        total++;
        if (pc !== 32'h0000_0100 || imem_addr !== 32'h0000_0100 || imem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL jump_0x100: pc=%h addr=%h req=%b want 100 100 1", pc, imem_addr, imem_req);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1000_FFFF;
        tick();
        // Stall in ISSUE: controls and ready are present but exec_done is low.
        imem_rdata = 32'h1234_5678;
        branch = 1'b1;
        zero = 1'b1;
        jump = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h1000_FFFF || opcode !== 6'h04) begin
                bad++;
                $display("[TB] FAIL issue_stall%0d: valid=%b pc=%h instr=%h op=%h want 1 100 1000ffff 04",
                         i, instr_valid, pc, instr, opcode);
            end
        end
        imem_ready = 1'b0;
        jump = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        branch = 1'b0;
        zero = 1'b0;
        total++;
        if (pc !== 32'h0000_0100 || imem_addr !== 32'h0000_0100) begin
            bad++;
            $display("[TB] FAIL branch_taken: pc=%h addr=%h want 100 100", pc, imem_addr);
        end
        fetch_issue(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        total++;
        if (pc !== 32'h0000_0104) begin
            bad++;
            $display("[TB] FAIL branch_not_taken: pc=%h want 104", pc);
        end
    endtask

    task automatic test_jump_jr();
        fetch_issue(32'h03E0_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0010);
        total++;
        if (pc !== 32'h1000_0010 || err_misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL jr_aligned: pc=%h err=%b want 10000010 0", pc, err_misalign);
        end
        fetch_issue(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        total++;
        if (pc !== 32'h1000_0100) begin
            bad++;
            $display("[TB] FAIL jump_region: pc=%h want 10000100", pc);
        end
        fetch_issue(32'h0800_0040, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_002A);
        total++;
        if (pc !== 32'h0000_0028 || err_misalign !== 1'b1) begin
            bad++;
            $display("[TB] FAIL jr_priority: pc=%h err=%b want 28 1", pc, err_misalign);
        end
        fetch_issue(32'h0022_1820, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++;
        if (pc !== 32'h0000_002C || err_misalign !== 1'b1 || instr_count !== 32'd10) begin
            bad++;
            $display("[TB] FAIL err_sticky: pc=%h err=%b cnt=%0d want 2c 1 10", pc, err_misalign, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0040;
        tick();
        imem_ready = 1'b0;
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_in_issue: valid=%b want 1", instr_valid);
        end
        exec_done = 1'b1;
        jump = 1'b1;
        rst = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_quiet: valid=%b req=%b want 0 0", instr_valid, imem_req);
        end
        total++;
        if (pc !== 32'd0 || instr_count !== 32'd0 || err_misalign !== 1'b0 || instr !== 32'd0) begin
            bad++;
            $display("[TB] FAIL mid_regs: pc=%h cnt=%0d err=%b instr=%h want 0 0 0 0",
                     pc, instr_count, err_misalign, instr);
        end
        exec_done = 1'b0;
        jump = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        rst1 = 1'b1;
        tick();
        tick();
        total++;
        if (imem_req1 !== 1'b1 || imem_addr1 !== 32'hFFFF_FFFC || pc_plus4_1 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL wrap_start: req=%b addr=%h pc4=%h want 1 fffffffc 0", imem_req1, imem_addr1, pc_plus4_1);
        end
        imem_ready1 = 1'b1;
        imem_rdata1 = 32'h0022_1820;
        tick();
        imem_ready1 = 1'b0;
        exec_done1 = 1'b1;
        tick();
        exec_done1 = 1'b0;
        total++;
        if (imem_req1 !== 1'b1 || imem_addr1 !== 32'd0 || err_misalign1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_fetch0: req=%b addr=%h err=%b want 1 0 0", imem_req1, imem_addr1, err_misalign1);
        end
        // Offset -8 from pc_plus4 = 4 lands below zero and wraps high.
        imem_ready1 = 1'b1;
        imem_rdata1 = 32'h1000_FFFE;
        tick();
        imem_ready1 = 1'b0;
        branch1 = 1'b1;
        zero1 = 1'b1;
        exec_done1 = 1'b1;
        tick();
        exec_done1 = 1'b0;
        branch1 = 1'b0;
        zero1 = 1'b0;
        total++;
        if (pc1 !== 32'hFFFF_FFFC || err_misalign1 !== 1'b0 || instr_count1 !== 32'd2) begin
            bad++;
            $display("[TB] FAIL wrap_branch: pc=%h err=%b cnt=%0d want fffffffc 0 2", pc1, err_misalign1, instr_count1);
        end
    endtask

    initial begin
        rst = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        exec_done = 1'b0;
        jump = 1'b0;
        branch = 1'b0;
        zero = 1'b0;
        adr_r31 = 1'b0;
        r31_data = 32'd0;
        rst1 = 1'b0;
        imem_ready1 = 1'b0;
        imem_rdata1 = 32'd0;
        exec_done1 = 1'b0;
        branch1 = 1'b0;
        zero1 = 1'b0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_jump_jr();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
